seq_addsub_nbit: RTL



---
 rtl/seq_addsub_nbit_if.sv | 26 ++
 rtl/seq_addsub_nbit.sv | 104 ++++++++++
 2 files changed

// File: rtl/seq_addsub_nbit_if.sv
// Request/response bundle for the digit-serial adder/subtractor.
// The requester holds the master modport; the arithmetic unit holds the slave modport.
interface seq_addsub_nbit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_addsub_nbit.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock through a registered carry.
// Results appear WIDTH/DIGIT cycles after start is sampled and hold until the next completion.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last completed operation
// RUN   | one operand digit consumed per clock, least significant digit first
module seq_addsub_nbit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    seq_addsub_nbit_if.slave bus
);
    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] beff_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]   dig_d;
    logic [WIDTH-1:0] psum_d;
    logic             ovf_d;

    // Each new digit enters at the top, so after NCYC digits the word is aligned.
    always_comb begin
        dig_d  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, beff_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        psum_d = WIDTH'({dig_d[DIGIT-1:0], psum_q} >> DIGIT);
        ovf_d  = (a_msb_q == b_msb_q) && (psum_d[WIDTH-1] != a_msb_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            beff_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + ~cin, so invert B and the incoming carry here.
                        a_q     <= bus.a;
                        beff_q  <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q <= bus.cin ^ bus.sub;
                        a_msb_q <= bus.a[WIDTH-1];
                        b_msb_q <= bus.b[WIDTH-1] ^ bus.sub;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    beff_q  <= beff_q >> DIGIT;
                    carry_q <= dig_d[DIGIT];
                    psum_q  <= psum_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        sum_q   <= psum_d;
                        cout_q  <= dig_d[DIGIT];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
